// File: rtl/latency_dual_port_memory.sv
// Behavioural main memory with independent instruction/data ports and per-port access latency.
// Build option: define MEM_DEBUG_EN for write/range-error tracing and all-X out-of-range read data.

module latency_dual_port_memory_ctrl #(
  parameter int unsigned LATENCY = 0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic ready_c,
  output logic accept_c,
  output logic resp_c
);
  localparam int unsigned CNT_BITS = 8;
  localparam logic [CNT_BITS-1:0] LAT = CNT_BITS'(LATENCY);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A request accepted in RESP reloads exactly as from IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_c  = 1'b0;
    accept_c = 1'b0;
    resp_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: ready_c = 1'b1;
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        ready_c = 1'b1;
        resp_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    accept_c = ready_c && req_i;
    if (accept_c) begin
      cnt_d   = LAT;
      state_d = (LAT == '0) ? ST_RESP : ST_WAIT;
    end
  end
endmodule

module latency_dual_port_memory #(
  parameter int unsigned           ADDR_BITS     = 32,
  parameter logic [ADDR_BITS-1:0]  BASE_ADDR     = ADDR_BITS'(32'h8000_0000),
  parameter int unsigned           DATA_BITS     = 32,
  parameter int unsigned           DEPTH_WORDS   = 2048,
  parameter int unsigned           INSTR_LATENCY = 0,
  parameter int unsigned           DATA_LATENCY  = 20,
  parameter string                 INIT_FILE     = ""
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   i_req_i,
  input  logic [ADDR_BITS-1:0]   i_addr_i,
  output logic                   i_ready_o,
  output logic                   i_done_o,
  output logic [DATA_BITS-1:0]   i_rdata_o,
  output logic                   i_err_o,
  input  logic                   d_req_i,
  input  logic                   d_we_i,
  input  logic [ADDR_BITS-1:0]   d_addr_i,
  input  logic [DATA_BITS-1:0]   d_wdata_i,
  input  logic [DATA_BITS/8-1:0] d_be_i,
  output logic                   d_ready_o,
  output logic                   d_done_o,
  output logic [DATA_BITS-1:0]   d_rdata_o,
  output logic                   d_err_o
);
  localparam int unsigned BYTES    = DATA_BITS / 8;
  localparam int unsigned OFF_BITS = $clog2(BYTES);
  localparam int unsigned IDX_BITS = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_BITS:0] SPAN = (ADDR_BITS+1)'(DEPTH_WORDS * BYTES);
`ifdef MEM_DEBUG_EN
  localparam logic [DATA_BITS-1:0] OOR_DATA = 'x;
`else
  localparam logic [DATA_BITS-1:0] OOR_DATA = '0;
`endif

  logic [DATA_BITS-1:0] mem [0:DEPTH_WORDS-1];

  initial begin
    for (int unsigned w = 0; w < DEPTH_WORDS; w++) mem[w] = '0;
  end

  function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
  endfunction

  function automatic logic [IDX_BITS-1:0] word_idx(input logic [ADDR_BITS-1:0] a);
    logic [ADDR_BITS-1:0] off;
    off = a - BASE_ADDR;
    return IDX_BITS'(off >> OFF_BITS);
  endfunction

  logic i_accept, i_resp, d_accept, d_resp;

  latency_dual_port_memory_ctrl #(.LATENCY(INSTR_LATENCY)) u_i_ctrl (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (i_req_i),
    .ready_c  (i_ready_o),
    .accept_c (i_accept),
    .resp_c   (i_resp)
  );

  latency_dual_port_memory_ctrl #(.LATENCY(DATA_LATENCY)) u_d_ctrl (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (d_req_i),
    .ready_c  (d_ready_o),
    .accept_c (d_accept),
    .resp_c   (d_resp)
  );

  // Latched request fields
  logic [ADDR_BITS-1:0] i_addr_q, d_addr_q;
  logic                 d_we_q;
  logic [DATA_BITS-1:0] d_wdata_q;
  logic [BYTES-1:0]     d_be_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_we_q    <= 1'b0;
      d_wdata_q <= '0;
      d_be_q    <= '0;
    end else begin
      if (i_accept) i_addr_q <= i_addr_i;
      if (d_accept) begin
        d_addr_q  <= d_addr_i;
        d_we_q    <= d_we_i;
        d_wdata_q <= d_wdata_i;
        d_be_q    <= d_be_i;
      end
    end
  end

  logic                 i_hit, d_hit, d_commit;
  logic [IDX_BITS-1:0]  i_idx, d_idx;
  logic [DATA_BITS-1:0] i_word, d_word, d_merged;

  assign i_hit    = in_range(i_addr_q);
  assign d_hit    = in_range(d_addr_q);
  assign i_idx    = word_idx(i_addr_q);
  assign d_idx    = word_idx(d_addr_q);
  assign i_word   = mem[i_idx];
  assign d_word   = mem[d_idx];
  assign d_commit = d_resp && d_we_q && d_hit;

  // Post-write word; equals the stored word for reads.
  always_comb begin
    d_merged = d_word;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (d_we_q && d_be_q[b]) d_merged[8*b +: 8] = d_wdata_q[8*b +: 8];
    end
  end

  // Memory array carries no reset so contents survive rst_ni.
  always @(posedge clk_i) begin
    if (d_commit) mem[d_idx] <= d_merged;
`ifdef MEM_DEBUG_EN
    if (d_commit) $display("MEM WRITE addr=%h data=%h be=%b", d_addr_q, d_wdata_q, d_be_q);
    if (i_resp && !i_hit) $display("MEM RANGE ERROR addr=%h port=I", i_addr_q);
    if (d_resp && !d_hit) $display("MEM RANGE ERROR addr=%h port=D", d_addr_q);
`endif
  end

  // Completion registers; an instruction read sees the pre-write word on a shared edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_done_o  <= 1'b0;
      i_rdata_o <= '0;
      i_err_o   <= 1'b0;
      d_done_o  <= 1'b0;
      d_rdata_o <= '0;
      d_err_o   <= 1'b0;
    end else begin
      i_done_o <= i_resp;
      d_done_o <= d_resp;
      if (i_resp) begin
        i_err_o   <= !i_hit;
        i_rdata_o <= i_hit ? i_word : OOR_DATA;
      end
      if (d_resp) begin
        d_err_o   <= !d_hit;
        d_rdata_o <= d_hit ? d_merged : OOR_DATA;
      end
    end
  end
endmodule

// File: tb/tb_latency_dual_port_memory.sv
// Directed bench for latency_dual_port_memory: vector table plus latency, collision and reset sequences.

module tb_latency_dual_port_memory;
  localparam int unsigned I_LAT = 0;
  localparam int unsigned D_LAT = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_ready, i_done, i_err;
  logic [31:0] i_addr = '0, i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0, d_ready, d_done, d_err;
  logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
  logic [3:0]  d_be = '0;

  logic        z_i_req = 1'b0, z_i_ready, z_i_done, z_i_err;
  logic [31:0] z_i_addr = '0, z_i_rdata;
  logic        z_d_req = 1'b0, z_d_we = 1'b0, z_d_ready, z_d_done, z_d_err;
  logic [31:0] z_d_addr = '0, z_d_wdata = '0, z_d_rdata;
  logic [3:0]  z_d_be = '0;

  always #5 clk = ~clk;

  latency_dual_port_memory #(.INSTR_LATENCY(I_LAT), .DATA_LATENCY(D_LAT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_ready_o(i_ready), .i_done_o(i_done),
    .i_rdata_o(i_rdata), .i_err_o(i_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_be_i(d_be),
    .d_ready_o(d_ready), .d_done_o(d_done), .d_rdata_o(d_rdata), .d_err_o(d_err)
  );

  latency_dual_port_memory #(.INSTR_LATENCY(0), .DATA_LATENCY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(z_i_req), .i_addr_i(z_i_addr), .i_ready_o(z_i_ready), .i_done_o(z_i_done),
    .i_rdata_o(z_i_rdata), .i_err_o(z_i_err),
    .d_req_i(z_d_req), .d_we_i(z_d_we), .d_addr_i(z_d_addr), .d_wdata_i(z_d_wdata), .d_be_i(z_d_be),
    .d_ready_o(z_d_ready), .d_done_o(z_d_done), .d_rdata_o(z_d_rdata), .d_err_o(z_d_err)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] bb_exp [4] = '{32'h0000_0013, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void add(input logic port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    v.exp_lat = port ? int'(D_LAT) + 1 : int'(I_LAT) + 1;
    vecs.push_back(v);
  endfunction

  // Issue one request on the main DUT at a negedge and wait (bounded) for its done pulse.
  task automatic access(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
    if (port) begin
      chk("d_ready_before_req", 32'(d_ready), 32'd1);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      chk("i_ready_before_req", 32'(i_ready), 32'd1);
      i_req = 1'b1; i_addr = addr;
    end
    @(negedge clk);
    i_req = 1'b0;
    d_req = 1'b0;
    lat = -1; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if ((port ? d_done : i_done) === 1'b1) begin
        lat   = c - 1;
        rdata = port ? d_rdata : i_rdata;
        err   = port ? d_err : i_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          ndone;

    add(1, 1, 32'h8000_0000, 32'h0000_0013, 4'hF, 32'h0000_0013, 0);
    add(1, 1, 32'h8000_0004, 32'h1111_1111, 4'hF, 32'h1111_1111, 0);
    add(1, 1, 32'h8000_0008, 32'h2222_2222, 4'hF, 32'h2222_2222, 0);
    add(1, 1, 32'h8000_000C, 32'h3333_3333, 4'hF, 32'h3333_3333, 0);
    add(0, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h0000_0013, 0);
    add(1, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 0);
    add(1, 0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0);
    add(1, 1, 32'h8000_0010, 32'h0000_1200, 4'h2, 32'hDEAD_12EF, 0);
    add(1, 0, 32'h8000_0013, 32'h0,         4'h0, 32'hDEAD_12EF, 0);
    add(0, 0, 32'h8000_0012, 32'h0,         4'h0, 32'hDEAD_12EF, 0);
    add(1, 0, 32'h8000_2000, 32'h0,         4'h0, 32'h0,         1);
    add(1, 1, 32'h8000_2000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1);
    add(0, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h0000_0013, 0);
    add(0, 0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1);
    add(0, 0, 32'h8000_1FFC, 32'h0,         4'h0, 32'h0,         0);
    add(1, 1, 32'h8000_1FFC, 32'hA5A5_A5A5, 4'h9, 32'hA500_00A5, 0);
    add(0, 0, 32'h8000_1FFC, 32'h0,         4'h0, 32'hA500_00A5, 0);
    add(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 32'h0000_0013, 0);
    add(0, 0, 32'h8000_0000, 32'h0,         4'h0, 32'h0000_0013, 0);

    #1;
    chk("rst_i_ready", 32'(i_ready), 32'd1);
    chk("rst_d_ready", 32'(d_ready), 32'd1);
    chk("rst_i_done",  32'(i_done),  32'd0);
    chk("rst_d_done",  32'(d_done),  32'd0);
    chk("rst_i_err",   32'(i_err),   32'd0);
    chk("rst_d_err",   32'(d_err),   32'd0);
    chk("rst_i_rdata", i_rdata,      32'd0);
    chk("rst_d_rdata", d_rdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse_width", i), 32'(vecs[i].port ? d_done : i_done), 32'd0);
      chk($sformatf("v%0d_ready_after", i), 32'(vecs[i].port ? d_ready : i_ready), 32'd1);
    end

    // Back-to-back zero-latency instruction fetches
    for (int n = 0; n <= 5; n++) begin
      if (n >= 2) begin
        chk($sformatf("bb%0d_done", n - 2), 32'(i_done), 32'd1);
        chk($sformatf("bb%0d_rdata", n - 2), i_rdata, bb_exp[n-2]);
      end else if (n == 1) begin
        chk("bb_done_not_early", 32'(i_done), 32'd0);
      end
      if (n < 4) begin
        chk($sformatf("bb%0d_ready", n), 32'(i_ready), 32'd1);
        i_req = 1'b1;
        i_addr = 32'h8000_0000 + 32'(4 * n);
      end else begin
        i_req = 1'b0;
      end
      @(negedge clk);
    end
    chk("bb_done_end", 32'(i_done), 32'd0);

    // Write request during a read's WAIT is ignored, not queued
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8000_0000;
    @(negedge clk);
    d_req = 1'b0;
    ndone = 0; rd = '0;
    for (int c = 0; c < 50; c++) begin
      if (c == 3) begin
        d_req = 1'b1; d_we = 1'b1; d_wdata = 32'h0; d_be = 4'hF;
      end
      if (c == 4) d_req = 1'b0;
      if (d_done === 1'b1) begin
        ndone++;
        rd = d_rdata;
      end
      @(negedge clk);
    end
    chk("busy_done_count", 32'(ndone), 32'd1);
    chk("busy_rdata", rd, 32'h0000_0013);
    access(0, 0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
    chk("busy_no_write", rd, 32'h0000_0013);

    // Reset in the middle of a write's WAIT
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8000_0010; d_wdata = 32'h0123_4567; d_be = 4'hF;
    @(negedge clk);
    d_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("wait_ready_low", 32'(d_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_d_ready", 32'(d_ready), 32'd1);
    chk("midrst_d_done",  32'(d_done),  32'd0);
    chk("midrst_d_rdata", d_rdata,      32'd0);
    chk("midrst_i_rdata", i_rdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (d_done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    access(1, 0, 32'h8000_0010, 32'h0, 4'h0, rd, er, lat);
    chk("midrst_word_kept", rd, 32'hDEAD_12EF);
    chk("midrst_read_latency", 32'(lat), 32'(D_LAT + 1));

    // Same-edge instruction read and data write with both latencies zero
    z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = 32'h8000_0004; z_d_wdata = 32'hAAAA_5555; z_d_be = 4'hF;
    @(negedge clk);
    z_d_req = 1'b0;
    @(negedge clk);
    chk("col_pre_done", 32'(z_d_done), 32'd1);
    chk("col_pre_rdata", z_d_rdata, 32'hAAAA_5555);
    z_i_req = 1'b1; z_i_addr = 32'h8000_0004;
    z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = 32'h8000_0004; z_d_wdata = 32'h1234_5678; z_d_be = 4'hF;
    @(negedge clk);
    z_i_req = 1'b0;
    z_d_req = 1'b0;
    @(negedge clk);
    chk("col_i_done", 32'(z_i_done), 32'd1);
    chk("col_i_old_value", z_i_rdata, 32'hAAAA_5555);
    chk("col_d_done", 32'(z_d_done), 32'd1);
    chk("col_d_new_value", z_d_rdata, 32'h1234_5678);
    z_i_req = 1'b1; z_i_addr = 32'h8000_0004;
    @(negedge clk);
    z_i_req = 1'b0;
    @(negedge clk);
    chk("col_next_i_done", 32'(z_i_done), 32'd1);
    chk("col_next_i_new_value", z_i_rdata, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
